// File: rtl/l2_evict_buffer_pkg.sv
// Shared types for the L2 write-back victim buffer.
package l2_evict_buffer_pkg;

  localparam int unsigned EVICT_DEPTH = 4;
  localparam int unsigned LINE_W      = 128;
  localparam int unsigned ADDR_W      = 16;
  localparam int unsigned TAG_W       = 12;

  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  addr;
    logic [LINE_W-1:0] data;
  } evict_entry_t;

  typedef enum logic [1:0] {
    IDLE,
    HIT,
    READ,
    DRAIN
  } evict_state_t;

endpackage

// File: rtl/l2_evict_buffer_match.sv
// Comparator array over the victim entries: youngest read hit and coalesce target.
module evict_match
  import l2_evict_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = EVICT_DEPTH,
  localparam int unsigned PW   = $clog2(DEPTH)
) (
  input  evict_entry_t [DEPTH-1:0] entries,
  input  logic [PW-1:0]            head,
  input  logic [TAG_W-1:0]         raddr,
  input  logic [TAG_W-1:0]         waddr,
  input  logic                     excl_head,
  output logic                     hit_c,
  output logic [PW-1:0]            hit_idx_c,
  output logic                     coal_c,
  output logic [PW-1:0]            coal_idx_c
);

  logic [PW-1:0] idx;

  // Walk oldest to youngest so the last match seen is the youngest.
  always_comb begin
    hit_c      = 1'b0;
    hit_idx_c  = '0;
    coal_c     = 1'b0;
    coal_idx_c = '0;
    idx        = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if (entries[idx].valid && entries[idx].addr == raddr) begin
        hit_c     = 1'b1;
        hit_idx_c = idx;
      end
      if (entries[idx].valid && entries[idx].addr == waddr &&
          !(excl_head && idx == head)) begin
        coal_c     = 1'b1;
        coal_idx_c = idx;
      end
    end
  end

endmodule

// File: rtl/l2_evict_buffer.sv
// Write-back victim buffer between L2 and physical memory: absorbs evictions, serves reads, drains FIFO.
module l2_evict_buffer
  import l2_evict_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = EVICT_DEPTH
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         l2_write,
  input  logic [15:0]  l2_waddr,
  input  logic [127:0] l2_wdata,
  output logic         l2_full,
  input  logic         l2_read,
  input  logic [15:0]  l2_raddr,
  output logic [127:0] l2_rdata,
  output logic         l2_resp,
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [15:0]  pmem_address,
  output logic [127:0] pmem_wdata,
  input  logic [127:0] pmem_rdata,
  input  logic         pmem_resp
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  evict_entry_t [DEPTH-1:0] ent;
  evict_state_t             state;
  logic [PW-1:0]            head, tail;
  logic [CW-1:0]            count, count_next;
  logic                     full_q;
  logic [LINE_W-1:0]        hit_data;
  logic [TAG_W-1:0]         rd_tag;

  logic          hit, coal;
  logic [PW-1:0] hit_idx, coal_idx;
  logic          push_ok, alloc, pop;
  logic          unused_addr_bits;

  assign unused_addr_bits = ^{l2_waddr[3:0], l2_raddr[3:0]};

  evict_match #(.DEPTH(DEPTH)) u_match (
    .entries    (ent),
    .head       (head),
    .raddr      (l2_raddr[15:4]),
    .waddr      (l2_waddr[15:4]),
    .excl_head  (state == DRAIN),
    .hit_c      (hit),
    .hit_idx_c  (hit_idx),
    .coal_c     (coal),
    .coal_idx_c (coal_idx)
  );

  assign push_ok    = l2_write & ~full_q;
  assign alloc      = push_ok & ~coal;
  assign pop        = (state == DRAIN) & pmem_resp;
  assign count_next = count + CW'(alloc) - CW'(pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      full_q   <= 1'b0;
      hit_data <= '0;
      rd_tag   <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) ent[i].valid <= 1'b0;
    end else begin
      if (push_ok) begin
        if (coal) begin
          ent[coal_idx].data <= l2_wdata;
        end else begin
          ent[tail] <= '{valid: 1'b1, addr: l2_waddr[15:4], data: l2_wdata};
          tail      <= tail + PW'(1);
        end
      end
      // Head and tail never coincide here: a pop needs count>0, a push at tail needs count<DEPTH.
      if (pop) begin
        ent[head].valid <= 1'b0;
        head            <= head + PW'(1);
      end
      count  <= count_next;
      full_q <= (count_next == CW'(DEPTH));

      case (state)
        IDLE: begin
          if (count == CW'(DEPTH)) begin
            state <= DRAIN;
          end else if (l2_read && hit) begin
            state    <= HIT;
            hit_data <= ent[hit_idx].data;
          end else if (l2_read) begin
            state  <= READ;
            rd_tag <= l2_raddr[15:4];
          end else if (count != '0) begin
            state <= DRAIN;
          end
        end
        HIT:     state <= IDLE;
        READ:    if (pmem_resp) state <= IDLE;
        DRAIN:   if (pmem_resp) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign l2_full = full_q;

  // Memory side follows state; the head line cannot change while it drains.
  always_comb begin
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    l2_resp      = 1'b0;
    l2_rdata     = '0;
    case (state)
      HIT: begin
        l2_resp  = 1'b1;
        l2_rdata = hit_data;
      end
      READ: begin
        pmem_read    = 1'b1;
        pmem_address = {rd_tag, 4'h0};
        if (pmem_resp) begin
          l2_resp  = 1'b1;
          l2_rdata = pmem_rdata;
        end
      end
      DRAIN: begin
        pmem_write   = 1'b1;
        pmem_address = {ent[head].addr, 4'h0};
        pmem_wdata   = ent[head].data;
      end
      default: ;
    endcase
  end

endmodule
